alu_datapath: RTL

Parametrised successor to the 4-bit ALU/ACC/R0 datapath. It merges the ALU, the accumulator and a REG_COUNT-entry register file into one block, driven by a VALID/READY op interface. It adds SUB, AND and a multi-cycle shift-add MUL, plus registered ZERO/CARRY flags. It sits between the future instruction decoder and the I/O bus.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_regfile.sv | 32 +++
 rtl/alu_datapath.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state encoding shared by the ALU datapath.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_MOVR  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: REG_COUNT x DATA_WIDTH general registers, synchronous
// active-high reset, one write port and one combinational read port.
module alu_regfile #(
  parameter int DATA_WIDTH = 4,
  parameter int REG_COUNT  = 4,
  localparam int SEL_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [SEL_WIDTH-1:0]  i_wsel,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [SEL_WIDTH-1:0]  i_rsel,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

  // Register storage: clear all entries on reset, otherwise write on i_we.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (i_we) begin
      r_regs[i_wsel] <= i_wdata;
    end
  end

  assign o_rdata = r_regs[i_rsel];

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath: accumulator ALU with register file, VALID/READY op interface,
// registered ZERO/CARRY flags and a multi-cycle shift-add multiplier.
// Optional build macro ALU_SAT_EN: saturating ADD/INC/SUB/MUL instead of
// modular wrap-around.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int REG_COUNT  = 4,
  parameter int OP_WIDTH   = 3,
  localparam int SEL_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN0,
  input  logic [OP_WIDTH-1:0]   OP,
  input  logic [SEL_WIDTH-1:0]  SEL,
  input  logic                  VALID,
  output logic                  READY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] ACC_OUT,
  output logic                  ZERO,
  output logic                  CARRY
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int PW = 2 * DATA_WIDTH;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_zero;
  logic                  r_carry;
  logic                  r_done;
  logic [PW-1:0]         r_mcand;
  logic [PW-1:0]         r_prod;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [CW-1:0]         r_step;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_is_mul;
  logic                  w_mul_last;
  logic                  w_store;
  logic [DATA_WIDTH-1:0] w_rd;
  logic [PW-1:0]         w_prod_next;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_inc;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_borrow;
  logic                  w_mul_hi_nz;
  logic                  w_acc_we;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic                  w_carry_next;

  assign w_accept   = VALID && w_ready;
  assign w_is_mul   = (OP == OP_MUL);
  assign w_store    = w_accept && (OP == OP_STORE);
  assign w_mul_last = (r_state == ST_MUL) && (r_step == CW'(DATA_WIDTH - 1));

  alu_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_regfile (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_we    (w_store),
    .i_wsel  (SEL),
    .i_wdata (r_acc),
    .i_rsel  (SEL),
    .o_rdata (w_rd)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: enter MUL on an accepted MUL, leave after the last step.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_next = ST_MUL;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_mul_last) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_MUL;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: the block only accepts ops while idle.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = 1'b1;
      ST_MUL:  w_ready = 1'b0;
      default: w_ready = 1'b0;
    endcase
  end

  // Arithmetic building blocks shared by the op decode below.
  always_comb begin
    w_sum       = {1'b0, IN0} + {1'b0, w_rd};
    w_inc       = {1'b0, r_acc} + {{DATA_WIDTH{1'b0}}, 1'b1};
    w_diff      = IN0 - w_rd;
    w_borrow    = (IN0 < w_rd);
    w_prod_next = r_prod + (r_mplier[0] ? r_mcand : {PW{1'b0}});
    w_mul_hi_nz = |w_prod_next[PW-1:DATA_WIDTH];
  end

  // Op decode: next accumulator value, carry flag and accumulator write enable.
  always_comb begin
    w_acc_we     = 1'b0;
    w_acc_next   = r_acc;
    w_carry_next = r_carry;
    if (w_mul_last) begin
      w_acc_we     = 1'b1;
      w_carry_next = w_mul_hi_nz;
`ifdef ALU_SAT_EN
      w_acc_next   = w_mul_hi_nz ? {DATA_WIDTH{1'b1}} : w_prod_next[DATA_WIDTH-1:0];
`else
      w_acc_next   = w_prod_next[DATA_WIDTH-1:0];
`endif
    end else if (w_accept) begin
      case (OP)
        OP_ADD: begin
          w_acc_we     = 1'b1;
          w_carry_next = w_sum[DATA_WIDTH];
`ifdef ALU_SAT_EN
          w_acc_next   = w_sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];
`else
          w_acc_next   = w_sum[DATA_WIDTH-1:0];
`endif
        end
        OP_LOAD: begin
          w_acc_we     = 1'b1;
          w_acc_next   = IN0;
          w_carry_next = 1'b0;
        end
        OP_INC: begin
          w_acc_we     = 1'b1;
          w_carry_next = w_inc[DATA_WIDTH];
`ifdef ALU_SAT_EN
          w_acc_next   = w_inc[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : w_inc[DATA_WIDTH-1:0];
`else
          w_acc_next   = w_inc[DATA_WIDTH-1:0];
`endif
        end
        OP_MOVR: begin
          w_acc_we     = 1'b1;
          w_acc_next   = w_rd;
          w_carry_next = 1'b0;
        end
        OP_SUB: begin
          w_acc_we     = 1'b1;
          w_carry_next = w_borrow;
`ifdef ALU_SAT_EN
          w_acc_next   = w_borrow ? {DATA_WIDTH{1'b0}} : w_diff;
`else
          w_acc_next   = w_diff;
`endif
        end
        OP_AND: begin
          w_acc_we     = 1'b1;
          w_acc_next   = r_acc & w_rd;
          w_carry_next = 1'b0;
        end
        default: begin
          // STORE and MUL leave ACC and flags alone at the accept edge.
          w_acc_we     = 1'b0;
          w_acc_next   = r_acc;
          w_carry_next = r_carry;
        end
      endcase
    end else begin
      w_acc_we     = 1'b0;
      w_acc_next   = r_acc;
      w_carry_next = r_carry;
    end
  end

  // Accumulator, flags and DONE pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc   <= {DATA_WIDTH{1'b0}};
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_acc_we) begin
        r_acc   <= w_acc_next;
        r_zero  <= (w_acc_next == {DATA_WIDTH{1'b0}});
        r_carry <= w_carry_next;
      end
      r_done <= (w_accept && !w_is_mul) || w_mul_last;
    end
  end

  // Shift-add multiplier: snapshot operands on accept, one step per MUL cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mcand  <= {PW{1'b0}};
      r_mplier <= {DATA_WIDTH{1'b0}};
      r_prod   <= {PW{1'b0}};
      r_step   <= {CW{1'b0}};
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= {{DATA_WIDTH{1'b0}}, r_acc};
      r_mplier <= w_rd;
      r_prod   <= {PW{1'b0}};
      r_step   <= {CW{1'b0}};
    end else if (r_state == ST_MUL) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_prod   <= w_prod_next;
      r_step   <= r_step + CW'(1);
    end
  end

  assign READY   = w_ready;
  assign DONE    = r_done;
  assign ACC_OUT = r_acc;
  assign ZERO    = r_zero;
  assign CARRY   = r_carry;

endmodule
